oped_axil_csr: RTL and testbench
================================

Name: oped_axil_csr

Overview:
- AXI4-Lite slave (responder) that terminates the OPED control-plane master (M_AXI_*), giving the fabric side a small control/status register bank.
- Decodes 32-bit word accesses into six registers: ID, scratch, control output, status input sample, free-running cycle counter, and write-1-to-clear event latches.
- Single outstanding write and single outstanding read; AW and W are accepted independently and in either order.
- Returns OKAY, SLVERR or DECERR per access.

Parameters:
- ID_VALUE, 32'h4F504544, value returned by the ID register.
- CTRL_RESET, 32'h0, reset value of the CONTROL register.
- NUM_EVENTS, 8, number of event inputs; legal range 1..32.
- ADDR_W, 8, number of decoded address bits (byte address); bits above ADDR_W are ignored.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  reset; asynchronous assert, active-low.
- S_AXI_AWADDR  in  32  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR  in  32  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.
- ctrl_o  out  32  CONTROL register contents.
- status_i  in  32  status input, sampled on read.
- event_i  in  NUM_EVENTS  single-cycle event pulses; set the matching EVENT bit.

Behaviour:
- Reset values (ARESETN low, asynchronous): all READY and VALID outputs 0; BRESP, RRESP and RDATA 0; SCRATCH 0; ctrl_o = CTRL_RESET; COUNT 0; EVENT 0.
- rdy_en register: set on the first ACLK edge after reset release. All READY outputs are gated by rdy_en.
- Register map, decoded from ADDR[ADDR_W-1:2]; ADDR[1:0] ignored:
  - 0x00 ID: RO.
  - 0x04 SCRATCH: RW.
  - 0x08 CONTROL: RW.
  - 0x0C STATUS: RO, reads status_i.
  - 0x10 COUNT: RO; +1 every cycle, wraps 0xFFFFFFFF -> 0.
  - 0x14 EVENT: W1C, upper unused bits read 0.
  - Any other offset is unmapped.
- Write channel:
  - AWREADY = rdy_en & ~aw_full & ~BVALID; WREADY = rdy_en & ~w_full & ~BVALID.
  - On handshake, latch address (or data and strobe) into the held register and set aw_full (or w_full).
  - Commit occurs at the first edge where aw_full & w_full & ~BVALID. At that edge:
    - update the target register;
    - set BVALID;
    - clear aw_full and w_full.
  - Minimum latency: AW and W both captured at edge E0, register updated and BVALID high after E1.
  - WSTRB applies per byte to SCRATCH and CONTROL.
  - On EVENT, bits with data=1 inside a strobed byte are cleared.
  - BRESP: OKAY for RW and EVENT; SLVERR for ID, STATUS and COUNT writes (no state change); DECERR for unmapped offsets (no state change).
  - BVALID holds with BRESP stable until the BREADY edge; that edge clears it.
- Read channel:
  - ARREADY = rdy_en & ~RVALID.
  - At the AR handshake edge: load RDATA and RRESP, set RVALID (one-cycle latency).
  - Unmapped offsets: RDATA 0, RRESP DECERR. All other offsets: RRESP OKAY.
  - RVALID, RDATA and RRESP hold stable until the RREADY edge, which clears RVALID. A new AR is accepted only from the following cycle.
- Simultaneous events:
  - A read capture and a write commit at the same edge to the same register: the read returns the pre-write value.
  - An event_i bit set and a W1C clear of the same bit in the same cycle: the set wins, and the bit reads 1.
  - COUNT read returns the value before that edge's increment.
- Read and write paths are fully independent; neither blocks the other.
- Reset mid-transaction abandons held AW and W state and any pending B or R. There is no replay.

Decomposition:
- Package oped_csr_pkg holds:
  - register offset constants;
  - resp constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - typedef for the held write request (addr, data, strb).
- One natural sub-module, oped_csr_regs: register storage, COUNT, EVENT set/clear, and read mux. The AXI handshake FSMs stay in the top module.

Test Plan:
- Reset release, read 0x00 with RREADY=1 -> ARREADY 0 until the first post-reset edge; RDATA 0x4F504544, RRESP 00, RVALID exactly one cycle.
- W presented 3 cycles before AW to 0x04, data 0xA5A5A5A5, WSTRB 4'b0101, then read back -> BRESP 00; read returns 0x00A500A5.
- Write 0x08 = 0x12345678 while BREADY is held low for 5 cycles -> ctrl_o = 0x12345678 one edge after the second handshake; BVALID stays high 5 cycles; AWREADY and WREADY low throughout.
- Write to 0x10 -> BRESP 10, COUNT unaffected. Write or read 0x40 -> BRESP or RRESP 11, read RDATA 0.
- Pulse event_i[3] and event_i[0]; read 0x14 -> 0x09. Write 0x14 = 0x08 in the same cycle event_i[3] pulses again -> subsequent read 0x09. Write 0x14 = 0x09 -> read 0x00.
- Assert ARESETN low while BVALID=1 and aw_full is set -> all outputs return to reset values immediately; ctrl_o = CTRL_RESET; the first post-reset write completes normally.

Source files
------------

// File: rtl/oped_csr_pkg.sv
// Shared definitions for the OPED AXI4-Lite control/status register block:
// register offsets, AXI response codes and the held write request.
package oped_csr_pkg;

    localparam logic [31:0] OFF_ID      = 32'h00;
    localparam logic [31:0] OFF_SCRATCH = 32'h04;
    localparam logic [31:0] OFF_CONTROL = 32'h08;
    localparam logic [31:0] OFF_STATUS  = 32'h0C;
    localparam logic [31:0] OFF_COUNT   = 32'h10;
    localparam logic [31:0] OFF_EVENT   = 32'h14;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        SEL_ID,
        SEL_SCRATCH,
        SEL_CONTROL,
        SEL_STATUS,
        SEL_COUNT,
        SEL_EVENT,
        SEL_NONE
    } reg_sel_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_req_t;

    function automatic reg_sel_e decode_off(input logic [31:0] off);
        reg_sel_e sel;
        case (off)
            OFF_ID:      sel = SEL_ID;
            OFF_SCRATCH: sel = SEL_SCRATCH;
            OFF_CONTROL: sel = SEL_CONTROL;
            OFF_STATUS:  sel = SEL_STATUS;
            OFF_COUNT:   sel = SEL_COUNT;
            OFF_EVENT:   sel = SEL_EVENT;
            default:     sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/oped_csr_regs.sv
// Register storage, free-running counter, W1C event latches and the
// combinational read mux; the AXI handshakes live in the top module.
module oped_csr_regs
    import oped_csr_pkg::*;
#(
    parameter logic [31:0] ID_VALUE   = 32'h4F504544,
    parameter logic [31:0] CTRL_RESET = 32'h0,
    parameter int          NUM_EVENTS = 8,
    parameter int          ADDR_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  wr_req_t               wr_req,
    output logic [1:0]            wr_resp,
    input  logic [31:0]           rd_addr,
    output logic [31:0]           rd_data,
    output logic [1:0]            rd_resp,
    input  logic [31:0]           status_i,
    input  logic [NUM_EVENTS-1:0] event_i,
    output logic [31:0]           ctrl_o
);

    logic [31:0]           scratch_q, scratch_d;
    logic [31:0]           ctrl_q, ctrl_d;
    logic [31:0]           count_q, count_d;
    logic [NUM_EVENTS-1:0] event_q, event_d;
    logic [31:0]           byte_mask;
    logic [31:0]           clr_bits;
    reg_sel_e              wr_sel, rd_sel;
    logic                  unused_bits;

    // Only ADDR[ADDR_W-1:2] selects a register; the byte lane bits are dropped.
    function automatic logic [31:0] word_off(input logic [31:0] a);
        return 32'({a[ADDR_W-1:2], 2'b00});
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_strb
        assign byte_mask[gi*8 +: 8] = {8{wr_req.strb[gi]}};
    end

    assign wr_sel      = decode_off(word_off(wr_req.addr));
    assign rd_sel      = decode_off(word_off(rd_addr));
    assign clr_bits    = wr_req.data & byte_mask;
    assign unused_bits = ^{wr_req.addr, rd_addr, clr_bits};

    always_comb begin
        scratch_d = scratch_q;
        ctrl_d    = ctrl_q;
        count_d   = count_q + 32'd1;
        event_d   = event_q | event_i;
        if (wr_en) begin
            case (wr_sel)
                SEL_SCRATCH: scratch_d = (scratch_q & ~byte_mask) | (wr_req.data & byte_mask);
                SEL_CONTROL: ctrl_d    = (ctrl_q & ~byte_mask) | (wr_req.data & byte_mask);
                // A new pulse on a bit being cleared keeps the bit set.
                SEL_EVENT:   event_d   = (event_q & ~clr_bits[NUM_EVENTS-1:0]) | event_i;
                default:     ;
            endcase
        end
    end

    always_comb begin
        case (wr_sel)
            SEL_SCRATCH, SEL_CONTROL, SEL_EVENT: wr_resp = RESP_OKAY;
            SEL_ID, SEL_STATUS, SEL_COUNT:       wr_resp = RESP_SLVERR;
            default:                             wr_resp = RESP_DECERR;
        endcase
    end

    always_comb begin
        rd_data = 32'h0;
        rd_resp = RESP_OKAY;
        case (rd_sel)
            SEL_ID:      rd_data = ID_VALUE;
            SEL_SCRATCH: rd_data = scratch_q;
            SEL_CONTROL: rd_data = ctrl_q;
            SEL_STATUS:  rd_data = status_i;
            SEL_COUNT:   rd_data = count_q;
            SEL_EVENT:   rd_data = 32'(event_q);
            default:     rd_resp = RESP_DECERR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scratch_q <= 32'h0;
            ctrl_q    <= CTRL_RESET;
            count_q   <= 32'h0;
            event_q   <= '0;
        end else begin
            scratch_q <= scratch_d;
            ctrl_q    <= ctrl_d;
            count_q   <= count_d;
            event_q   <= event_d;
        end
    end

    assign ctrl_o = ctrl_q;

endmodule

// File: rtl/oped_axil_csr.sv
// AXI4-Lite responder for the OPED control plane: independent AW/W capture,
// one outstanding write and one outstanding read, registered read data.
module oped_axil_csr
    import oped_csr_pkg::*;
#(
    parameter logic [31:0] ID_VALUE   = 32'h4F504544,
    parameter logic [31:0] CTRL_RESET = 32'h0,
    parameter int          NUM_EVENTS = 8,
    parameter int          ADDR_W     = 8
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [31:0]           S_AXI_AWADDR,
    input  logic [2:0]            S_AXI_AWPROT,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [31:0]           S_AXI_WDATA,
    input  logic [3:0]            S_AXI_WSTRB,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [31:0]           S_AXI_ARADDR,
    input  logic [2:0]            S_AXI_ARPROT,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [31:0]           S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    output logic [31:0]           ctrl_o,
    input  logic [31:0]           status_i,
    input  logic [NUM_EVENTS-1:0] event_i
);

    wr_req_t     req_q, req_d;
    logic        aw_full_q, aw_full_d;
    logic        w_full_q, w_full_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        rvalid_q, rvalid_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rdy_en_q, rdy_en_d;
    logic        aw_hs, w_hs, ar_hs, commit;
    logic [1:0]  wr_resp, rd_resp;
    logic [31:0] rd_data;
    logic        unused_prot;

    assign unused_prot   = ^{S_AXI_AWPROT, S_AXI_ARPROT};
    assign rdy_en_d      = 1'b1;

    assign S_AXI_AWREADY = rdy_en_q & ~aw_full_q & ~bvalid_q;
    assign S_AXI_WREADY  = rdy_en_q & ~w_full_q & ~bvalid_q;
    assign S_AXI_ARREADY = rdy_en_q & ~rvalid_q;
    assign aw_hs         = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs          = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs         = S_AXI_ARVALID & S_AXI_ARREADY;
    assign commit        = aw_full_q & w_full_q & ~bvalid_q;

    always_comb begin
        req_d     = req_q;
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (aw_hs) begin
            req_d.addr = S_AXI_AWADDR;
            aw_full_d  = 1'b1;
        end
        if (w_hs) begin
            req_d.data = S_AXI_WDATA;
            req_d.strb = S_AXI_WSTRB;
            w_full_d   = 1'b1;
        end
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_resp;
        end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end
    end

    // Read data is captured from the pre-edge register values, so a same-edge
    // write commit or COUNT increment is not visible to this read.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_data;
            rresp_d  = rd_resp;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            req_q     <= '0;
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0;
            rresp_q   <= RESP_OKAY;
            rdy_en_q  <= 1'b0;
        end else begin
            req_q     <= req_d;
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rdy_en_q  <= rdy_en_d;
        end
    end

    assign S_AXI_BVALID = bvalid_q;
    assign S_AXI_BRESP  = bresp_q;
    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RDATA  = rdata_q;
    assign S_AXI_RRESP  = rresp_q;

    oped_csr_regs #(
        .ID_VALUE   (ID_VALUE),
        .CTRL_RESET (CTRL_RESET),
        .NUM_EVENTS (NUM_EVENTS),
        .ADDR_W     (ADDR_W)
    ) u_regs (
        .clk      (ACLK),
        .rst_n    (ARESETN),
        .wr_en    (commit),
        .wr_req   (req_q),
        .wr_resp  (wr_resp),
        .rd_addr  (S_AXI_ARADDR),
        .rd_data  (rd_data),
        .rd_resp  (rd_resp),
        .status_i (status_i),
        .event_i  (event_i),
        .ctrl_o   (ctrl_o)
    );

endmodule

// File: tb/tb_oped_axil_csr.sv
// Directed bench for oped_axil_csr: hand sequences for handshake ordering,
// back-pressure, events and reset, plus a table of single accesses.
module tb_oped_axil_csr;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [31:0] S_AXI_AWADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [31:0] S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_ARPROT = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic [31:0] ctrl_o;
    logic [31:0] status_i = 32'hCAFEF00D;
    logic [7:0]  event_i = '0;

    int n_pass = 0;
    int n_total = 0;
    int unsigned cyc = 0;

    always #5 ACLK = ~ACLK;

    // Edges since reset release; equals the expected COUNT value between edges.
    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    oped_axil_csr dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .ctrl_o(ctrl_o), .status_i(status_i), .event_i(event_i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL %s: no handshake within 20 cycles", name);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
        bit aw_go, w_go, b_go;
        int n;
        resp = 2'bxx;
        S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
        S_AXI_BREADY = 1'b1;
        for (n = 0; n < 20; n++) begin
            aw_go = S_AXI_AWVALID && S_AXI_AWREADY;
            w_go  = S_AXI_WVALID && S_AXI_WREADY;
            b_go  = S_AXI_BVALID;
            if (b_go) resp = S_AXI_BRESP;
            tick();
            if (aw_go) S_AXI_AWVALID = 1'b0;
            if (w_go) S_AXI_WVALID = 1'b0;
            if (b_go) break;
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        if (n == 20) timeout("write");
        $display("write addr=%h data=%h strb=%b bresp=%b", a, d, s, resp);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] data,
                           output logic [1:0] resp, output int unsigned hs_cyc);
        bit ar_go, r_go;
        int n;
        data = 'x; resp = 2'bxx; hs_cyc = 0;
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
        for (n = 0; n < 20; n++) begin
            ar_go = S_AXI_ARVALID && S_AXI_ARREADY;
            if (ar_go) hs_cyc = cyc;
            r_go = S_AXI_RVALID;
            if (r_go) begin
                data = S_AXI_RDATA;
                resp = S_AXI_RRESP;
            end
            tick();
            if (ar_go) S_AXI_ARVALID = 1'b0;
            if (r_go) break;
        end
        S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        if (n == 20) timeout("read");
        $display("read  addr=%h rdata=%h rresp=%b", a, data, resp);
    endtask

    typedef struct {
        bit          wr;
        bit          cnt;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [17];

    initial begin
        logic [31:0] d;
        logic [1:0] r;
        int unsigned hc;

        // Table of single accesses; scratch=00A500A5, ctrl=12345678 when applied.
        vecs[0]  = '{1'b0, 1'b0, 32'h04,  32'h0,        4'hF, 2'b00, 32'h00A500A5};
        vecs[1]  = '{1'b0, 1'b0, 32'h08,  32'h0,        4'hF, 2'b00, 32'h12345678};
        vecs[2]  = '{1'b0, 1'b1, 32'h10,  32'h0,        4'hF, 2'b00, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h10,  32'hFFFFFFFF, 4'hF, 2'b10, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 32'h10,  32'h0,        4'hF, 2'b00, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 32'h40,  32'h11111111, 4'hF, 2'b11, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 32'h40,  32'h0,        4'hF, 2'b11, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 32'h00,  32'h22222222, 4'hF, 2'b10, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 32'h00,  32'h0,        4'hF, 2'b00, 32'h4F504544};
        vecs[9]  = '{1'b1, 1'b0, 32'h0C,  32'h33333333, 4'hF, 2'b10, 32'h0};
        vecs[10] = '{1'b0, 1'b0, 32'h0C,  32'h0,        4'hF, 2'b00, 32'hCAFEF00D};
        vecs[11] = '{1'b1, 1'b0, 32'h08,  32'hAABBCCDD, 4'h8, 2'b00, 32'h0};
        vecs[12] = '{1'b0, 1'b0, 32'h08,  32'h0,        4'hF, 2'b00, 32'hAA345678};
        vecs[13] = '{1'b0, 1'b0, 32'h107, 32'h0,        4'hF, 2'b00, 32'h00A500A5};
        vecs[14] = '{1'b0, 1'b0, 32'h1C,  32'h0,        4'hF, 2'b11, 32'h0};
        vecs[15] = '{1'b1, 1'b0, 32'h05,  32'h0000FF00, 4'h2, 2'b00, 32'h0};
        vecs[16] = '{1'b0, 1'b0, 32'h04,  32'h0,        4'hF, 2'b00, 32'h00A5FFA5};

        // Reset values, no clock edge needed
        #2;
        check("rst ready", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'h0);
        check("rst valid", 32'({S_AXI_BVALID, S_AXI_RVALID}), 32'h0);
        check("rst data", S_AXI_RDATA, 32'h0);
        check("rst resp", 32'({S_AXI_BRESP, S_AXI_RRESP}), 32'h0);
        check("rst ctrl", ctrl_o, 32'h0);

        // Release, then read ID with RREADY held high
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        S_AXI_ARADDR = 32'h0; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
        check("arready pre-edge", 32'(S_AXI_ARREADY), 32'h0);
        tick();
        check("arready post-edge", 32'(S_AXI_ARREADY), 32'h1);
        check("rvalid before hs", 32'(S_AXI_RVALID), 32'h0);
        tick();
        S_AXI_ARVALID = 1'b0;
        check("id rvalid", 32'(S_AXI_RVALID), 32'h1);
        check("id rdata", S_AXI_RDATA, 32'h4F504544);
        check("id rresp", 32'(S_AXI_RRESP), 32'h0);
        tick();
        check("id rvalid one cycle", 32'(S_AXI_RVALID), 32'h0);
        S_AXI_RREADY = 1'b0;
        $display("read  addr=00000000 rdata=4f504544 (first after reset)");

        // W three cycles ahead of AW to SCRATCH
        S_AXI_WDATA = 32'hA5A5A5A5; S_AXI_WSTRB = 4'b0101; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
        check("w ready", 32'(S_AXI_WREADY), 32'h1);
        tick();
        S_AXI_WVALID = 1'b0;
        check("w held", 32'({S_AXI_WREADY, S_AXI_BVALID}), 32'h0);
        tick(); tick();
        S_AXI_AWADDR = 32'h04; S_AXI_AWVALID = 1'b1;
        check("aw ready", 32'(S_AXI_AWREADY), 32'h1);
        tick();
        S_AXI_AWVALID = 1'b0;
        check("late aw no bvalid", 32'(S_AXI_BVALID), 32'h0);
        tick();
        check("late aw b", 32'({S_AXI_BVALID, S_AXI_BRESP}), 32'b100);
        tick();
        check("late aw b cleared", 32'(S_AXI_BVALID), 32'h0);
        S_AXI_BREADY = 1'b0;
        $display("write addr=00000004 data=a5a5a5a5 strb=0101 (W first)");

        // CONTROL write with BREADY low for five cycles
        S_AXI_AWADDR = 32'h08; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h12345678; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        check("ctrl before commit", ctrl_o, 32'h0);
        tick();
        check("ctrl after commit", ctrl_o, 32'h12345678);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp cycle%0d bvalid/awready/wready", k),
                  32'({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}), 32'b100);
            if (k < 4) tick();
        end
        S_AXI_BREADY = 1'b1;
        tick();
        check("bp b cleared", 32'(S_AXI_BVALID), 32'h0);
        S_AXI_BREADY = 1'b0;
        $display("write addr=00000008 data=12345678 (BREADY stalled)");

        for (int i = 0; i < 17; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
                check($sformatf("vec%0d bresp", i), 32'(r), 32'(vecs[i].resp));
            end else begin
                do_read(vecs[i].addr, d, r, hc);
                check($sformatf("vec%0d rresp", i), 32'(r), 32'(vecs[i].resp));
                check($sformatf("vec%0d rdata", i), d, vecs[i].cnt ? 32'(hc) : vecs[i].rdata);
            end
        end
        check("ctrl_o byte write", ctrl_o, 32'hAA345678);

        // Events: set, clear racing a re-set, full clear
        event_i = 8'h09;
        tick();
        event_i = 8'h00;
        do_read(32'h14, d, r, hc);
        check("event set", d, 32'h09);
        S_AXI_AWADDR = 32'h14; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h08; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
        check("w1c ready", 32'({S_AXI_AWREADY, S_AXI_WREADY}), 32'b11);
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        event_i = 8'h08;
        tick();
        event_i = 8'h00;
        check("w1c b", 32'({S_AXI_BVALID, S_AXI_BRESP}), 32'b100);
        tick();
        S_AXI_BREADY = 1'b0;
        $display("write addr=00000014 data=00000008 (racing event)");
        do_read(32'h14, d, r, hc);
        check("event set wins", d, 32'h09);
        do_write(32'h14, 32'h09, 4'hF, r);
        check("w1c bresp", 32'(r), 32'h0);
        do_read(32'h14, d, r, hc);
        check("event cleared", d, 32'h00);

        // Read capture at the same edge as a SCRATCH commit sees the old value
        S_AXI_AWADDR = 32'h04; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        S_AXI_ARADDR = 32'h04; S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_ARVALID = 1'b0;
        check("rw same edge rdata", S_AXI_RDATA, 32'h00A5FFA5);
        check("rw same edge valids", 32'({S_AXI_RVALID, S_AXI_BVALID}), 32'b11);
        S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
        $display("write addr=00000004 data=deadbeef with same-edge read");
        do_read(32'h04, d, r, hc);
        check("rw new value", d, 32'hDEADBEEF);

        // Reset while a write response and a read response are both pending
        S_AXI_AWADDR = 32'h00; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 32'h0C; S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        tick();
        check("pend b", 32'({S_AXI_BVALID, S_AXI_BRESP}), 32'b110);
        check("pend r", S_AXI_RDATA, 32'hCAFEF00D);
        #2 ARESETN = 1'b0;
        #1;
        check("mid rst valids", 32'({S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_ARREADY}), 32'h0);
        check("mid rst resp/data", 32'({S_AXI_BRESP, S_AXI_RRESP}) | S_AXI_RDATA, 32'h0);
        check("mid rst ctrl", ctrl_o, 32'h0);
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        tick();

        // Abandoned AW must not pair with the first post-reset write
        S_AXI_AWADDR = 32'h08; S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        check("aw held", 32'({S_AXI_AWREADY, S_AXI_WREADY}), 32'b01);
        #2 ARESETN = 1'b0;
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        tick();
        do_write(32'h04, 32'h11223344, 4'hF, r);
        check("post rst bresp", 32'(r), 32'h0);
        check("post rst ctrl", ctrl_o, 32'h0);
        do_read(32'h04, d, r, hc);
        check("post rst scratch", d, 32'h11223344);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
